// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control-step sequencer for two- and three-register ALU instructions.
// Fetches T0-T2 (with memory wait), decodes IR, then drives operand/ALU/write-back strobes T3-T5.

module alu_op_reg_slice #(
  parameter int IDX = 0
) (
  input  logic [3:0] wr_idx,
  input  logic [3:0] rd_idx,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic       r_in,
  output logic       r_out
);
  assign r_in  = wr_en && (wr_idx == 4'(IDX));
  assign r_out = rd_en && (rd_idx == 4'(IDX));
endmodule

module alu_op_sequencer #(
  parameter int WORD  = 32,
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [WORD-1:0]  ir,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic [OPW-1:0]   alu_op,
  output logic [NREGS-1:0] r_in,
  output logic [NREGS-1:0] r_out
);
  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [3:0]     ra;
    logic [3:0]     rb;
    logic [3:0]     rc;
    logic           bin;
    logic           un;
    logic           legal;
  } dec_t;

  state_t     state;
  dec_t       dec;
  logic       rd_en;
  logic       wr_en;
  logic [3:0] rd_idx;
  logic       unused_ir;

  assign unused_ir = ^ir;

  function automatic logic reg_ok(input logic [3:0] idx);
    return ({1'b0, idx} < 5'(NREGS));
  endfunction

  always_comb begin
    dec       = '0;
    dec.op    = ir[31 -: OPW];
    dec.ra    = ir[26:23];
    dec.rb    = ir[22:19];
    dec.rc    = ir[18:15];
    dec.bin   = (dec.op >= OPW'(3)) && (dec.op <= OPW'(11));
    dec.un    = (dec.op == OPW'(16)) || (dec.op == OPW'(17));
    // unary ops never read rc, so an out-of-range rc does not trap them
    dec.legal = (dec.bin && reg_ok(dec.ra) && reg_ok(dec.rb) && reg_ok(dec.rc)) ||
                (dec.un  && reg_ok(dec.ra) && reg_ok(dec.rb));
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    state <= mem_ready ? S_T2 : S_T1W;
        S_T1W:   if (mem_ready) state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3:    state <= dec.legal ? S_T4 : S_IDLE;
        S_T4:    state <= S_T5;
        S_T5:    state <= start ? S_T0 : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state != S_IDLE);
    done    = 1'b0;
    error   = 1'b0;
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    alu_op  = '0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    rd_idx  = dec.rb;
    case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      // wait cycles keep the read open but must not reload PC
      S_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        error = !dec.legal;
        Yin   = dec.legal && dec.bin;
        rd_en = dec.legal && dec.bin;
      end
      S_T4: begin
        Zin    = 1'b1;
        alu_op = dec.op;
        rd_en  = 1'b1;
        rd_idx = dec.bin ? dec.rc : dec.rb;
      end
      S_T5: begin
        Zlowout = 1'b1;
        done    = 1'b1;
        wr_en   = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    alu_op_reg_slice #(.IDX(i)) u_slice (
      .wr_idx (dec.ra),
      .rd_idx (rd_idx),
      .wr_en  (wr_en),
      .rd_en  (rd_en),
      .r_in   (r_in[i]),
      .r_out  (r_out[i])
    );
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed + randomized instruction streams checked against a
// per-instruction control-step trace model; instances with NREGS=16 and NREGS=8.

module tb_alu_op_sequencer;
  typedef struct packed {
    logic busy, done, error, PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic [4:0]  alu_op;
    logic [15:0] r_in;
    logic [15:0] r_out;
  } obs_t;

  typedef struct {
    logic        start;
    logic        mr;
    logic        tgt;
    logic [31:0] ir;
    int          cm;
    obs_t        exp;
  } step_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic [13:0] a_s, b_s;
  logic [4:0]  a_op, b_op;
  logic [15:0] a_rin, a_rout;
  logic [7:0]  b_rin, b_rout;
  obs_t        obs_a, obs_b;
  step_t       plan[$];
  step_t       cur;
  bit          cur_valid = 1'b0;
  obs_t        hist_a[$];
  obs_t        hist_b[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  assign obs_a = {a_s, a_op, a_rin, a_rout};
  assign obs_b = {b_s, b_op, 8'h00, b_rin, 8'h00, b_rout};

  alu_op_sequencer #(.WORD(32), .NREGS(16), .OPW(5)) dut_a (
    .clock(clock), .clear(clear), .start(start_a), .mem_ready(mem_ready), .ir(ir),
    .busy(a_s[13]), .done(a_s[12]), .error(a_s[11]), .PCout(a_s[10]), .MARin(a_s[9]),
    .IncPC(a_s[8]), .Zin(a_s[7]), .Zlowout(a_s[6]), .PCin(a_s[5]), .Read(a_s[4]),
    .MDRin(a_s[3]), .MDRout(a_s[2]), .IRin(a_s[1]), .Yin(a_s[0]),
    .alu_op(a_op), .r_in(a_rin), .r_out(a_rout)
  );

  alu_op_sequencer #(.WORD(32), .NREGS(8), .OPW(5)) dut_b (
    .clock(clock), .clear(clear), .start(start_b), .mem_ready(mem_ready), .ir(ir),
    .busy(b_s[13]), .done(b_s[12]), .error(b_s[11]), .PCout(b_s[10]), .MARin(b_s[9]),
    .IncPC(b_s[8]), .Zin(b_s[7]), .Zlowout(b_s[6]), .PCin(b_s[5]), .Read(b_s[4]),
    .MDRin(b_s[3]), .MDRout(b_s[2]), .IRin(b_s[1]), .Yin(b_s[0]),
    .alu_op(b_op), .r_in(b_rin), .r_out(b_rout)
  );

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] mkir(input int op, input int ra, input int rb, input int rc);
    logic [31:0] v;
    v = {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'h0000};
    return v;
  endfunction

  task automatic push(input logic st, input logic tg, input logic [31:0] irv, input int cm,
                      input obs_t e, input logic mr);
    step_t s;
    s.start = st; s.tgt = tg; s.ir = irv; s.cm = cm; s.exp = e; s.mr = mr;
    plan.push_back(s);
  endtask

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) push(1'b0, 1'b0, $urandom, 0, '0, rbit());
  endtask

  task automatic add_clear(input int n);
    for (int k = 0; k < n; k++) push(1'b0, 1'b0, $urandom, 1, '0, rbit());
  endtask

  // Expected control-step trace of one instruction, appended to the plan.
  task automatic build_instr(input logic [31:0] irv, input int waits, input logic tg,
                             input bit from_idle, input bit chain, input bit abort,
                             output bit chained);
    int n;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    bit bin, un, legal;
    obs_t e;
    n = tg ? 8 : 16;
    op = irv[31:27]; ra = irv[26:23]; rb = irv[22:19]; rc = irv[18:15];
    bin = (op >= 3 && op <= 11);
    un = (op == 16 || op == 17);
    legal = bin ? (ra < n && rb < n && rc < n) : (un && ra < n && rb < n);
    chained = 1'b0;
    if (from_idle) push(1'b1, tg, irv, 0, '0, rbit());
    e = '0; e.busy = 1; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1;
    push(rbit(), tg, irv, 0, e, rbit());
    e = '0; e.busy = 1; e.Zlowout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1;
    push(rbit(), tg, irv, 0, e, waits == 0);
    for (int k = 0; k < waits; k++) begin
      e = '0; e.busy = 1; e.Read = 1; e.MDRin = 1;
      push(rbit(), tg, irv, 0, e, k == waits - 1);
    end
    e = '0; e.busy = 1; e.MDRout = 1; e.IRin = 1;
    push(rbit(), tg, irv, 0, e, rbit());
    e = '0; e.busy = 1;
    if (!legal) begin
      e.error = 1;
      push(rbit(), tg, irv, 0, e, rbit());
      return;
    end
    if (bin) begin e.Yin = 1; e.r_out = 16'd1 << rb; end
    push(rbit(), tg, irv, 0, e, rbit());
    if (abort) begin
      push(rbit(), tg, irv, 2, '0, rbit());
      push(1'b0, tg, irv, 0, '0, rbit());
      return;
    end
    e = '0; e.busy = 1; e.Zin = 1; e.alu_op = op; e.r_out = 16'd1 << (bin ? rc : rb);
    push(rbit(), tg, irv, 0, e, rbit());
    e = '0; e.busy = 1; e.Zlowout = 1; e.done = 1; e.r_in = 16'd1 << ra;
    push(chain, tg, irv, 0, e, rbit());
    chained = chain;
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  // every planned cycle: both instances against the model
  always @(negedge clock) begin
    if (cur_valid) begin
      obs_t ea, eb;
      ea = '0;
      eb = '0;
      if (cur.tgt) eb = cur.exp; else ea = cur.exp;
      checks += 2;
      if (obs_a !== ea) begin
        errors++;
        $display("FAIL step%0d_a: got %h expected %h", hist_a.size(), obs_a, ea);
      end
      if (obs_b !== eb) begin
        errors++;
        $display("FAIL step%0d_b: got %h expected %h", hist_b.size(), obs_b, eb);
      end
      hist_a.push_back(obs_a);
      hist_b.push_back(obs_b);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ch;
    logic tg;
    int dq[$];
    int exp_done[6];
    int c_busy, c_pcin, c_read, c_mdrin, c_rin, c_err, c_rinb;

    add_clear(2); add_idle(1);
    build_instr(32'h28918000, 0, 1'b0, 1, 0, 0, ch); add_idle(1);
    build_instr(32'h28918000, 3, 1'b0, 1, 0, 0, ch); add_idle(1);
    build_instr(32'h80900000, 0, 1'b0, 1, 0, 0, ch); add_idle(1);
    build_instr(32'hF8000000, 0, 1'b0, 1, 0, 0, ch); add_idle(1);
    build_instr(mkir(3, 4, 5, 6), 0, 1'b0, 1, 1, 0, ch);
    build_instr(mkir(4, 7, 8, 0), 0, 1'b0, 0, 0, 0, ch); add_idle(1);
    build_instr(32'h28918000, 0, 1'b0, 1, 0, 1, ch); add_idle(1);
    build_instr(mkir(17, 15, 14, 0), 0, 1'b0, 1, 0, 0, ch); add_idle(1);
    build_instr(32'h1C890000, 0, 1'b1, 1, 0, 0, ch); add_idle(1);
    build_instr(mkir(9, 7, 6, 5), 0, 1'b1, 1, 0, 0, ch); add_idle(1);

    ch = 1'b0; tg = 1'b0;
    repeat (150) begin
      logic [4:0] op;
      int sel, rmax;
      logic [31:0] irv;
      if (!ch) begin
        tg = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) add_idle($urandom_range(1, 3));
      end
      sel = $urandom_range(0, 9);
      if (sel < 6) op = 5'($urandom_range(3, 11));
      else if (sel < 8) op = 5'($urandom_range(16, 17));
      else if (sel == 8) begin
        do op = 5'($urandom_range(0, 31));
        while ((op >= 3 && op <= 11) || op == 16 || op == 17);
      end else op = 5'($urandom_range(0, 31));
      rmax = tg ? 9 : 15;
      irv = mkir(op, $urandom_range(0, rmax), $urandom_range(0, rmax), $urandom_range(0, rmax))
            | ($urandom & 32'h7FFF);
      build_instr(irv, $urandom_range(0, 3), tg, !ch, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 24) == 0, ch);
    end
    if (ch) build_instr(mkir(3, 1, 2, 3), 0, tg, 0, 0, 0, ch);
    add_idle(2);

    foreach (plan[i]) begin
      @(posedge clock); #1;
      clear     = (plan[i].cm == 1);
      start_a   = plan[i].tgt ? 1'b0 : plan[i].start;
      start_b   = plan[i].tgt ? plan[i].start : 1'b0;
      mem_ready = plan[i].mr;
      ir        = plan[i].ir;
      cur       = plan[i];
      cur_valid = 1'b1;
      if (plan[i].cm == 2) begin #2; clear = 1'b1; end
    end
    @(posedge clock); #1;
    cur_valid = 1'b0;

    // hand-computed expectations for the directed section
    chk("model_t3_rout", plan[7].exp.r_out, 4);
    chk("model_t5_done", plan[20].exp.done, 1);
    chk("model_neg_aluop", plan[27].exp.alu_op, 16);
    chk("model_illegal_err", plan[34].exp.error, 1);

    exp_done = '{9, 20, 28, 42, 48, 64};
    for (int i = 0; i < 66; i++) if (hist_a[i].done) dq.push_back(i);
    chk("done_count_a", dq.size(), 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("done_at_%0d", k), (k < dq.size()) ? dq[k] : -1, exp_done[k]);

    c_busy = 0; c_pcin = 0; c_read = 0; c_mdrin = 0; c_rin = 0; c_err = 0; c_rinb = 0;
    for (int i = 3; i <= 10; i++) c_busy += int'(hist_a[i].busy);
    for (int i = 11; i <= 21; i++) begin
      c_pcin  += int'(hist_a[i].PCin);
      c_read  += int'(hist_a[i].Read);
      c_mdrin += int'(hist_a[i].MDRin);
    end
    for (int i = 30; i <= 35; i++) c_rin += (hist_a[i].r_in != 0) ? 1 : 0;
    for (int i = 0; i < 66; i++) c_err += int'(hist_a[i].error);
    for (int i = 66; i <= 71; i++) c_rinb += (hist_b[i].r_in != 0) ? 1 : 0;
    chk("busy_cycles_a", c_busy, 6);
    chk("pcin_once_wait", c_pcin, 1);
    chk("read_cycles_wait", c_read, 4);
    chk("mdrin_cycles_wait", c_mdrin, 4);
    chk("illegal_no_rin_a", c_rin, 0);
    chk("error_count_a", c_err, 1);
    chk("error_at_t3_a", hist_a[34].error, 1);
    chk("and_t3_rout", hist_a[7].r_out, 4);
    chk("and_t4_rout", hist_a[8].r_out, 8);
    chk("and_t4_aluop", hist_a[8].alu_op, 5);
    chk("and_t5_rin", hist_a[9].r_in, 2);
    chk("neg_t3_nostrobe", (hist_a[26].r_out != 0 || hist_a[26].Yin) ? 1 : 0, 0);
    chk("neg_t4_rout", hist_a[27].r_out, 4);
    chk("neg_t5_rin", hist_a[28].r_in, 2);
    chk("clear_mid_t4", (hist_a[55] != 0) ? 1 : 0, 0);
    chk("after_clear_busy", hist_a[56].busy, 0);
    chk("n8_error_t3", hist_b[70].error, 1);
    chk("n8_illegal_no_rin", c_rinb, 0);
    chk("n8_legal_rin", hist_b[78].r_in, 128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Control-step sequencer for three-register and two-register ALU instructions on the bus datapath. After `start`, it fetches the instruction (T0–T2), decodes the instruction register, and issues one-hot control strobes for the operand, ALU and write-back steps (T3–T5). It replaces hand-sequenced control and adds a memory-ready wait state, configurable register count, unary operations and illegal-instruction trapping. It sits between the top-level control and the DataPath control inputs.

Parameters:
WORD, 32, instruction/IR width (≥32)
NREGS, 16, number of general registers (2..16); register-index fields stay 4 bits wide
OPW, 5, opcode width; IR[31:32-OPW]

Ports:
clock  in  1  system clock; all state changes on rising edge
clear  in  1  asynchronous active-high reset
start  in  1  begin an instruction; sampled in IDLE and in T5
mem_ready  in  1  memory read data valid on Mdatain this cycle
ir  in  WORD  current IR contents; must stay stable from T3 through T5
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in T5 (successful write-back)
error  out  1  one-cycle pulse in T3 when the instruction is illegal
PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes
alu_op  out  OPW  ALU function select; equals the IR opcode in T4, 0 otherwise
r_in  out  NREGS  one-hot register write enable
r_out  out  NREGS  one-hot register bus-drive enable

Behaviour:
- Reset: `clear` high forces state to IDLE asynchronously, including mid-instruction.
  - All outputs are 0 while `clear` is high and in IDLE.
  - No partial step completes.
- Outputs are decoded combinationally from state (plus IR in T3–T5). Each strobe is high for exactly the cycles listed and 0 in all other cycles.
- IR field decode:
  - op = IR[31:27]
  - ra = IR[26:23] (destination)
  - rb = IR[22:19]
  - rc = IR[18:15]
- Binary opcodes: 3 add, 4 sub, 5 and, 6 or, 7 shr, 8 shra, 9 shl, 10 ror, 11 rol.
- Unary opcodes: 16 neg, 17 not.
- Any other opcode is illegal. An instruction is also illegal if any used register index is ≥ NREGS (rc is not checked for unary ops).
- States and transitions:
  - IDLE: start=1 → T0; otherwise stay.
  - T0: PCout, MARin, IncPC, Zin → T1.
  - T1: Zlowout, PCin, Read, MDRin.
    - mem_ready=1 → T2.
    - mem_ready=0 → T1W.
  - T1W: Read, MDRin only; PC is not reloaded again.
    - mem_ready=1 → T2; otherwise stay, with no timeout.
  - T2: MDRout, IRin → T3.
  - T3 (legal binary op): r_out[rb], Yin → T4.
  - T3 (legal unary op): no strobes → T4.
  - T3 (illegal): error=1, no strobes → IDLE. No T4/T5 and no register write.
  - T4 (binary op): r_out[rc], alu_op=op, Zin → T5.
  - T4 (unary op): r_out[rb], alu_op=op, Zin → T5.
  - T5: Zlowout, r_in[ra], done=1.
    - start=1 → T0 (back-to-back instruction, no IDLE bubble).
    - start=0 → IDLE.
- Latency: start sampled high in IDLE → write-back in T5, 6 cycles later with mem_ready constantly 1. Each mem_ready=0 cycle in T1 adds 1 cycle.
- `start` is ignored outside IDLE and T5. Asserting `start` while busy does not restart the sequence.
- Register index 0 is treated as an ordinary register, with no special zero handling.
- r_in and r_out are never both non-zero in the same cycle. At most one bit of each is set.

Test Plan:
- Reset, then ir=32'h28918000 (and R1,R2,R3), start pulse, mem_ready=1:
  - T3: r_out=0x0004, Yin.
  - T4: r_out=0x0008, alu_op=5, Zin.
  - T5: r_in=0x0002, Zlowout, done.
  - busy is high for exactly 6 cycles.
- Same instruction with mem_ready held 0 for 3 cycles in T1:
  - PCin is high exactly once.
  - Read/MDRin stay high for 4 cycles.
  - done arrives 9 cycles after start.
- ir=32'h80900000 (neg R1,R2), i.e. op 16, ra=1, rb=2:
  - T3 has no strobes.
  - T4: r_out=0x0004, alu_op=16.
  - T5: r_in=0x0002.
- Illegal cases: ir=32'hF8000000 (op 31), and NREGS=8 with ra=9:
  - error pulses in T3.
  - No r_in ever asserted.
  - State returns to IDLE on the next cycle.
- start held high across two instructions: T5 of the first goes directly to T0 of the second; two done pulses are 6 cycles apart.
- clear asserted asynchronously mid-T4:
  - All outputs drop to 0 before the next clock edge.
  - After release, state is IDLE and busy=0.
  - A new start runs a full sequence correctly.
